i2c_rank_seq: RTL and testbench
===============================

Name: i2c_rank_seq

Overview:
- Master-side transaction sequencer for the game's I2C peripheral link (slave address 7'h55, fixed 4-byte frame: command + 3 data bytes).
- Arbitrates between two requesters: port 0 = live FND score updater, port 1 = ranking manager.
- Expands each granted request into byte-level ops (START/WRITE/READ/STOP) for a byte-level I2C master engine.
- For read commands (0xA1..0xA5) it follows the write frame with a repeated 4-byte read frame and returns the 32-bit result.

Parameters:
- SLV_ADDR, 7'h55, 7-bit target address; addr byte = {SLV_ADDR, rw}
- RETRY_MAX, 3, max frame restarts on NACK (only with I2C_RANK_SEQ_RETRY_EN)
- TIMEOUT_CYC, 4096, max clk cycles waiting for a byte-engine response

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- r0_valid / r1_valid  in  1  request pending, port 0 / port 1
- r0_ready / r1_ready  out  1  one-cycle grant/accept pulse
- r0_cmd / r1_cmd  in  8  command byte (0x01, 0x11..0x42, 0xA1..0xA5)
- r0_data / r1_data  in  24  data bytes A,B,C; [23:16] is sent first
- r0_rd / r1_rd  in  1  append read frame after the write frame
- done_valid  out  1  one-cycle completion pulse
- done_id  out  1  port that owned the transaction
- done_err  out  2  00 ok, 01 addr NACK, 10 data NACK, 11 timeout
- done_rdata  out  32  read bytes, first byte in [31:24]; 0 if not rd or on error
- bc_valid  out  1  byte-op request to engine
- bc_ready  in  1  engine accepts op
- bc_op  out  2  0 START, 1 WRITE, 2 READ, 3 STOP
- bc_wdata  out  8  write byte
- bc_nack  out  1  on READ: master sends NACK (last byte)
- bc_rsp_valid  in  1  op finished
- bc_rsp_ack_n  in  1  on WRITE: slave NACKed
- bc_rsp_rdata  in  8  on READ: received byte
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, all outputs 0, RR pointer = port 1 (so port 0 wins first tie), retry count 0. Reset mid-transaction abandons it: no done pulse, bc_valid drops the same cycle.
- Arbitration in IDLE:
  - Single valid port is granted.
  - Both valid: grant the port not granted last; pointer updates on every grant.
  - Grant cycle: rX_ready=1, latch cmd/data/rd/id, go to W_START.
  - Requests are never accepted outside IDLE.
- Op step (every state except IDLE/DONE):
  - Hold bc_valid/bc_op/bc_wdata/bc_nack stable until bc_valid&bc_ready.
  - Then wait for bc_rsp_valid. A bc_rsp_valid in the handshake cycle itself is accepted.
  - Timeout counter starts at the handshake. At TIMEOUT_CYC without response: err=11, go to STOP_E.
- States:
  - W_START -> W_ADDR ({SLV_ADDR,0}) -> W_BYTE x4 (cmd, data[23:16], [15:8], [7:0]; byte index 0..3) -> W_STOP.
  - W_STOP -> R_START if rd, else DONE.
  - R_START -> R_ADDR ({SLV_ADDR,1}) -> R_BYTE x4; bc_nack=1 only on index 3; bytes shifted into rdata MSB-first -> R_STOP -> DONE.
  - DONE: one-cycle done_valid with id/err/rdata, then IDLE. done_rdata/done_err hold until the next done.
- NACK handling:
  - bc_rsp_ack_n on an ADDR op: err=01. On a BYTE op: err=10.
  - Either -> STOP_E (issue STOP) -> DONE with the error and rdata=0.
  - A NACK during the read frame's R_ADDR is also err=01.
- No read-frame data byte is checked for ack_n.
- Widths: byte index 2 bits wraps only via explicit state exit; timeout counter $clog2(TIMEOUT_CYC+1) bits, saturating.

Optional Feature:
- Macro I2C_RANK_SEQ_RETRY_EN.
- Defined:
  - A NACK (err 01/10) goes to STOP_E and then back to W_START. The whole transaction restarts, including the write frame of a rd request.
  - Restarts continue while retry count < RETRY_MAX; the count increments per restart.
  - After RETRY_MAX restarts the error is reported normally.
  - Timeout is never retried. The retry count clears on grant.
- Not defined: the first NACK is reported immediately; RETRY_MAX is unused.

Decomposition:
- Package i2c_rank_pkg:
  - bc_op encodings (OP_START..OP_STOP)
  - err codes
  - state enum
  - command constants (CMD_FND=8'h01, CMD_R1A=8'h11 … CMD_RD5=8'hA5)
  - default SLV_ADDR.
- Sub-module i2c_rank_rr_arb: 2-port round-robin arbiter with pointer register. Main FSM, byte counter, timeout and retry logic stay in i2c_rank_seq.

Test Plan:
- r0 cmd 01, data 0x2A0000, rd 0, engine always acks -> ops START, W AA, W 01, W 2A, W 00, W 00, STOP; done id0 err00.
- r1 cmd A1, rd 1, engine returns 12,34,56,78 -> write frame, STOP, START, W AB, 4 READs with bc_nack only on the 4th, STOP; done_rdata 0x12345678.
- r0 and r1 valid in the same cycle, repeatedly -> grants alternate 0,1,0,1; each ready is exactly one pulse.
- Addr byte NACKed:
  - Without macro: STOP then done err01.
  - With macro and RETRY_MAX=3: 4 frames are attempted, then err01. If the 2nd attempt acks, the result is err00.
- Engine withholds bc_rsp_valid after the W_BYTE handshake for TIMEOUT_CYC=16 cycles -> STOP issued, done err11, no retry.
- Reset asserted during R_BYTE index 2 -> bc_valid=0 and busy=0 the same cycle, no done pulse; the next request runs cleanly.

Source files
------------

// File: rtl/i2c_rank_pkg.sv
// rtl/i2c_rank_pkg.sv - shared encodings, states and command constants for the I2C ranking-link sequencer
package i2c_rank_pkg;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_STOP  = 2'd3
  } bc_op_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_ADDR = 2'b01;
  localparam logic [1:0] ERR_DATA = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_W_START, S_W_ADDR, S_W_BYTE, S_W_STOP,
    S_R_START, S_R_ADDR, S_R_BYTE, S_R_STOP, S_STOP_E, S_DONE
  } state_t;

  localparam logic [6:0] DEF_SLV_ADDR = 7'h55;

  localparam logic [7:0] CMD_FND = 8'h01;
  localparam logic [7:0] CMD_R1A = 8'h11;
  localparam logic [7:0] CMD_R4B = 8'h42;
  localparam logic [7:0] CMD_RD1 = 8'hA1;
  localparam logic [7:0] CMD_RD2 = 8'hA2;
  localparam logic [7:0] CMD_RD3 = 8'hA3;
  localparam logic [7:0] CMD_RD4 = 8'hA4;
  localparam logic [7:0] CMD_RD5 = 8'hA5;

  // Byte sent at frame position idx: command first, then data MSB byte first
  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [7:0] cmd,
                                            input logic [23:0] data);
    case (idx)
      2'd0:    return cmd;
      2'd1:    return data[23:16];
      2'd2:    return data[15:8];
      default: return data[7:0];
    endcase
  endfunction

endpackage

// File: rtl/i2c_rank_rr_arb.sv
// rtl/i2c_rank_rr_arb.sv - two-port round-robin arbiter; pointer holds the last granted port
module i2c_rank_rr_arb (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic ptr;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en && !reset) begin
      if (req0 && req1) begin
        gnt0 = ptr;
        gnt1 = ~ptr;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Reset to port 1 so port 0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ptr <= 1'b1;
    else if (gnt0) ptr <= 1'b0;
    else if (gnt1) ptr <= 1'b1;
  end

endmodule

// File: rtl/i2c_rank_seq.sv
// rtl/i2c_rank_seq.sv - two-port I2C frame sequencer driving a byte engine; I2C_RANK_SEQ_RETRY_EN enables NACK restarts
module i2c_rank_seq
  import i2c_rank_pkg::*;
#(
  parameter logic [6:0] SLV_ADDR    = DEF_SLV_ADDR,
  parameter int         RETRY_MAX   = 3,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  input  logic        r1_valid,
  output logic        r0_ready,
  output logic        r1_ready,
  input  logic [7:0]  r0_cmd,
  input  logic [7:0]  r1_cmd,
  input  logic [23:0] r0_data,
  input  logic [23:0] r1_data,
  input  logic        r0_rd,
  input  logic        r1_rd,
  output logic        done_valid,
  output logic        done_id,
  output logic [1:0]  done_err,
  output logic [31:0] done_rdata,
  output logic        bc_valid,
  input  logic        bc_ready,
  output logic [1:0]  bc_op,
  output logic [7:0]  bc_wdata,
  output logic        bc_nack,
  input  logic        bc_rsp_valid,
  input  logic        bc_rsp_ack_n,
  input  logic [7:0]  bc_rsp_rdata,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
`ifdef I2C_RANK_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  state_t        state, ns;
  logic [1:0]    idx, nidx, err_r, nerr;
  logic [7:0]    cmd_r;
  logic [23:0]   data_r;
  logic          rd_r, id_r;
  logic [31:0]   acc, nacc;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          wait_rsp, hs, rsp, tmo_hit, nack, retry, step;
  logic          gnt0, gnt1;

  i2c_rank_rr_arb u_arb (
    .clk  (clk),
    .reset(reset),
    .en   (state == S_IDLE),
    .req0 (r0_valid),
    .req1 (r1_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;
  assign busy     = (state != S_IDLE);

  // Packed {op, wdata, nack} presented when entering state s at byte index i
  function automatic logic [10:0] op_for(input state_t s, input logic [1:0] i);
    case (s)
      S_W_START, S_R_START: return {OP_START, 8'h00, 1'b0};
      S_W_ADDR:             return {OP_WRITE, SLV_ADDR, 1'b0, 1'b0};
      S_R_ADDR:             return {OP_WRITE, SLV_ADDR, 1'b1, 1'b0};
      S_W_BYTE:             return {OP_WRITE, frame_byte(i, cmd_r, data_r), 1'b0};
      S_R_BYTE:             return {OP_READ, 8'h00, (i == 2'd3)};
      default:              return {OP_STOP, 8'h00, 1'b0};
    endcase
  endfunction

  always_comb begin
    hs      = bc_valid & bc_ready;
    rsp     = bc_rsp_valid & (hs | wait_rsp);
    tmo_hit = wait_rsp & ~bc_rsp_valid & (tmo_cnt >= TMO_LAST);
    nack    = bc_rsp_ack_n & (state == S_W_ADDR || state == S_W_BYTE || state == S_R_ADDR);
    retry   = RETRY_EN && (err_r != ERR_TMO) && (retry_cnt < RW'(RETRY_MAX));
    step    = rsp | tmo_hit;
    ns      = state;
    nidx    = idx;
    nerr    = err_r;
    nacc    = acc;
    if (tmo_hit) begin
      nerr = ERR_TMO;
      ns   = (state == S_STOP_E) ? S_DONE : S_STOP_E;
    end else if (rsp) begin
      case (state)
        S_W_START: ns = S_W_ADDR;
        S_W_ADDR: begin
          if (nack) begin nerr = ERR_ADDR; ns = S_STOP_E; end
          else begin ns = S_W_BYTE; nidx = 2'd0; end
        end
        S_W_BYTE: begin
          if (nack)              begin nerr = ERR_DATA; ns = S_STOP_E; end
          else if (idx == 2'd3)  ns = S_W_STOP;
          else                   nidx = idx + 2'd1;
        end
        S_W_STOP:  ns = rd_r ? S_R_START : S_DONE;
        S_R_START: ns = S_R_ADDR;
        S_R_ADDR: begin
          if (nack) begin nerr = ERR_ADDR; ns = S_STOP_E; end
          else begin ns = S_R_BYTE; nidx = 2'd0; end
        end
        S_R_BYTE: begin
          nacc = {acc[23:0], bc_rsp_rdata};
          if (idx == 2'd3) ns = S_R_STOP;
          else             nidx = idx + 2'd1;
        end
        S_R_STOP:  ns = S_DONE;
        S_STOP_E:  ns = retry ? S_W_START : S_DONE;
        default:   ns = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      err_r      <= ERR_OK;
      cmd_r      <= 8'h00;
      data_r     <= 24'h0;
      rd_r       <= 1'b0;
      id_r       <= 1'b0;
      acc        <= 32'h0;
      retry_cnt  <= '0;
      tmo_cnt    <= '0;
      wait_rsp   <= 1'b0;
      bc_valid   <= 1'b0;
      bc_op      <= 2'd0;
      bc_wdata   <= 8'h00;
      bc_nack    <= 1'b0;
      done_valid <= 1'b0;
      done_id    <= 1'b0;
      done_err   <= 2'b00;
      done_rdata <= 32'h0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt0 || gnt1) begin
            id_r      <= gnt1;
            cmd_r     <= gnt1 ? r1_cmd : r0_cmd;
            data_r    <= gnt1 ? r1_data : r0_data;
            rd_r      <= gnt1 ? r1_rd : r0_rd;
            err_r     <= ERR_OK;
            acc       <= 32'h0;
            idx       <= 2'd0;
            retry_cnt <= '0;
            wait_rsp  <= 1'b0;
            state     <= S_W_START;
            {bc_op, bc_wdata, bc_nack} <= {OP_START, 8'h00, 1'b0};
            bc_valid  <= 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: begin
          if (hs) begin
            bc_valid <= 1'b0;
            wait_rsp <= 1'b1;
            tmo_cnt  <= '0;
          end else if (wait_rsp && tmo_cnt != {TW{1'b1}}) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
          if (step) begin
            state    <= ns;
            idx      <= nidx;
            err_r    <= nerr;
            acc      <= nacc;
            wait_rsp <= 1'b0;
            if (ns == S_DONE) begin
              done_valid <= 1'b1;
              done_id    <= id_r;
              done_err   <= nerr;
              done_rdata <= (nerr == ERR_OK && rd_r) ? nacc : 32'h0;
            end else begin
              {bc_op, bc_wdata, bc_nack} <= op_for(ns, nidx);
              bc_valid <= 1'b1;
            end
            // A restart replays the whole transaction from a clean slate
            if (state == S_STOP_E && ns == S_W_START) begin
              retry_cnt <= retry_cnt + 1'b1;
              err_r     <= ERR_OK;
              acc       <= 32'h0;
              idx       <= 2'd0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_rank_seq.sv
// tb/tb_i2c_rank_seq.sv - scoreboard bench for i2c_rank_seq with a behavioural byte engine
module tb_i2c_rank_seq;
  import i2c_rank_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        r0_valid = 1'b0, r1_valid = 1'b0;
  logic        r0_ready, r1_ready;
  logic [7:0]  r0_cmd = 8'h00, r1_cmd = 8'h00;
  logic [23:0] r0_data = 24'h0, r1_data = 24'h0;
  logic        r0_rd = 1'b0, r1_rd = 1'b0;
  logic        done_valid, done_id;
  logic [1:0]  done_err;
  logic [31:0] done_rdata;
  logic        bc_valid;
  logic        bc_ready = 1'b1;
  logic [1:0]  bc_op;
  logic [7:0]  bc_wdata;
  logic        bc_nack;
  logic        bc_rsp_valid = 1'b0, bc_rsp_ack_n = 1'b0;
  logic [7:0]  bc_rsp_rdata = 8'h00;
  logic        busy;

  always #5 clk = ~clk;

  i2c_rank_seq #(.SLV_ADDR(7'h55), .RETRY_MAX(3), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r1_valid(r1_valid), .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_cmd(r0_cmd), .r1_cmd(r1_cmd), .r0_data(r0_data), .r1_data(r1_data),
    .r0_rd(r0_rd), .r1_rd(r1_rd),
    .done_valid(done_valid), .done_id(done_id), .done_err(done_err), .done_rdata(done_rdata),
    .bc_valid(bc_valid), .bc_ready(bc_ready), .bc_op(bc_op), .bc_wdata(bc_wdata),
    .bc_nack(bc_nack), .bc_rsp_valid(bc_rsp_valid), .bc_rsp_ack_n(bc_rsp_ack_n),
    .bc_rsp_rdata(bc_rsp_rdata), .busy(busy)
  );

  int n_tests = 0, n_fail = 0;
  logic [10:0] got_q[$], exp_q[$];
  logic [34:0] done_q[$], dexp_q[$];
  int          gnt_q[$], gexp_q[$];
  logic [7:0]  rd_bytes[$];
  int nack_addr_left = 0, nack_data_left = 0, withhold_at = -1, op_idx = 0;
  int pulse_err = 0, hold_err = 0, last_gnt = 1;
  bit fast = 0, stall = 0, pend = 0, after_start = 0, prev_stalled = 0, p0 = 0, p1 = 0;
  logic        p_ack_n;
  logic [7:0]  p_rdata;
  logic [10:0] prev_op;

  // Byte engine and output monitor, evaluated mid low phase
  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      pend = 0; bc_rsp_valid = 1'b0; after_start = 0; prev_stalled = 0; p0 = 0; p1 = 0;
    end else begin
      bc_rsp_valid = 1'b0;
      if (pend) begin
        bc_rsp_valid = 1'b1; bc_rsp_ack_n = p_ack_n; bc_rsp_rdata = p_rdata; pend = 0;
      end
      if (prev_stalled && (!bc_valid || {bc_op, bc_wdata, bc_nack} !== prev_op)) hold_err++;
      bc_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bc_valid && bc_ready) begin
        p_ack_n = 1'b0; p_rdata = 8'h00;
        if (bc_op == OP_WRITE) begin
          if (after_start) begin
            if (nack_addr_left > 0) begin p_ack_n = 1'b1; nack_addr_left--; end
          end else if (nack_data_left > 0) begin
            p_ack_n = 1'b1; nack_data_left--;
          end
        end
        if (bc_op == OP_READ && rd_bytes.size() > 0) p_rdata = rd_bytes.pop_front();
        after_start = (bc_op == OP_START);
        got_q.push_back({bc_op, bc_wdata, bc_nack});
        if (op_idx != withhold_at) begin
          if (fast) begin
            bc_rsp_valid = 1'b1; bc_rsp_ack_n = p_ack_n; bc_rsp_rdata = p_rdata;
          end else pend = 1;
        end
        op_idx++;
      end
      prev_stalled = bc_valid && !bc_ready;
      prev_op = {bc_op, bc_wdata, bc_nack};
      if (done_valid) done_q.push_back({done_id, done_err, done_rdata});
      if (r0_ready) gnt_q.push_back(0);
      if (r1_ready) gnt_q.push_back(1);
      if ((r0_ready && p0) || (r1_ready && p1)) pulse_err++;
      p0 = r0_ready; p1 = r1_ready;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void exp_op(input logic [1:0] op, input logic [7:0] b, input logic n);
    exp_q.push_back({op, b, n});
  endfunction

  function automatic void exp_wframe(input logic [7:0] c, input logic [23:0] d);
    exp_op(OP_START, 8'h00, 1'b0);
    exp_op(OP_WRITE, 8'hAA, 1'b0);
    exp_op(OP_WRITE, c, 1'b0);
    exp_op(OP_WRITE, d[23:16], 1'b0);
    exp_op(OP_WRITE, d[15:8], 1'b0);
    exp_op(OP_WRITE, d[7:0], 1'b0);
    exp_op(OP_STOP, 8'h00, 1'b0);
  endfunction

  function automatic void exp_rframe();
    exp_op(OP_START, 8'h00, 1'b0);
    exp_op(OP_WRITE, 8'hAB, 1'b0);
    for (int i = 0; i < 4; i++) exp_op(OP_READ, 8'h00, (i == 3));
    exp_op(OP_STOP, 8'h00, 1'b0);
  endfunction

  function automatic void exp_addr_nack();
    exp_op(OP_START, 8'h00, 1'b0);
    exp_op(OP_WRITE, 8'hAA, 1'b0);
    exp_op(OP_STOP, 8'h00, 1'b0);
  endfunction

  function automatic int count_reads();
    int n = 0;
    foreach (got_q[i]) if (got_q[i][10:9] == OP_READ) n++;
    return n;
  endfunction

  task automatic req(input int p, input logic [7:0] c, input logic [23:0] d, input logic rd);
    bit got = 0;
    @(negedge clk);
    if (p == 0) begin r0_valid = 1; r0_cmd = c; r0_data = d; r0_rd = rd; end
    else        begin r1_valid = 1; r1_cmd = c; r1_data = d; r1_rd = rd; end
    for (int i = 0; i < 500 && !got; i++) begin
      #1;
      got = (p == 0) ? r0_ready : r1_ready;
      if (!got) @(negedge clk);
    end
    chk("req_accepted", 64'(got), 64'd1);
    @(posedge clk);
    #1;
    r0_valid = 0; r1_valid = 0;
    gexp_q.push_back(p);
    last_gnt = p;
  endtask

  task automatic tie(input logic [23:0] d0, input logic [23:0] d1);
    int first;
    bit g0 = 0, g1 = 0, n0, n1;
    first = (last_gnt == 1) ? 0 : 1;
    exp_wframe(CMD_FND, first == 0 ? d0 : d1);
    exp_wframe(CMD_FND, first == 0 ? d1 : d0);
    dexp_q.push_back({1'(first), ERR_OK, 32'h0});
    dexp_q.push_back({1'(1 - first), ERR_OK, 32'h0});
    gexp_q.push_back(first);
    gexp_q.push_back(1 - first);
    @(negedge clk);
    r0_valid = 1; r0_cmd = CMD_FND; r0_data = d0; r0_rd = 0;
    r1_valid = 1; r1_cmd = CMD_FND; r1_data = d1; r1_rd = 0;
    for (int i = 0; i < 500 && !(g0 && g1); i++) begin
      #1;
      n0 = r0_ready; n1 = r1_ready;
      @(posedge clk);
      #1;
      if (n0) begin r0_valid = 0; g0 = 1; end
      if (n1) begin r1_valid = 0; g1 = 1; end
      if (!(g0 && g1)) @(negedge clk);
    end
    chk("tie_both_granted", {62'b0, g0, g1}, 64'd3);
    r0_valid = 0; r1_valid = 0;
    last_gnt = 1 - first;
  endtask

  task automatic finish_scn(input string tag);
    int k = 0;
    while ((done_q.size() < dexp_q.size() || busy) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_in_time"}, 64'(k < 3000), 64'd1);
    chk({tag, "_n_ops"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_op"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    chk({tag, "_n_done"}, 64'(done_q.size()), 64'(dexp_q.size()));
    while (done_q.size() > 0 && dexp_q.size() > 0)
      chk({tag, "_done"}, 64'(done_q.pop_front()), 64'(dexp_q.pop_front()));
    chk({tag, "_n_gnt"}, 64'(gnt_q.size()), 64'(gexp_q.size()));
    while (gnt_q.size() > 0 && gexp_q.size() > 0)
      chk({tag, "_gnt"}, 64'(gnt_q.pop_front()), 64'(gexp_q.pop_front()));
    got_q.delete(); exp_q.delete(); done_q.delete(); dexp_q.delete();
    gnt_q.delete(); gexp_q.delete(); rd_bytes.delete();
    op_idx = 0; withhold_at = -1; nack_addr_left = 0; nack_data_left = 0;
    fast = 0; stall = 0;
  endtask

  initial begin
    bit found = 0;
    #1;
    chk("rst_bc_valid", 64'(bc_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    chk("rst_done_err", 64'(done_err), 64'd0);
    chk("rst_done_rdata", 64'(done_rdata), 64'd0);
    repeat (2) @(negedge clk);
    reset = 0;

    exp_wframe(CMD_FND, 24'h2A0000);
    dexp_q.push_back({1'b0, ERR_OK, 32'h0});
    req(0, CMD_FND, 24'h2A0000, 1'b0);
    finish_scn("fnd_write");

    fast = 1; stall = 1;
    rd_bytes.push_back(8'h12); rd_bytes.push_back(8'h34);
    rd_bytes.push_back(8'h56); rd_bytes.push_back(8'h78);
    exp_wframe(CMD_RD1, 24'h000003);
    exp_rframe();
    dexp_q.push_back({1'b1, ERR_OK, 32'h12345678});
    req(1, CMD_RD1, 24'h000003, 1'b1);
    finish_scn("rd_frame");
    repeat (5) @(negedge clk);
    chk("rdata_hold", 64'(done_rdata), 64'h12345678);

    tie(24'h100001, 24'h200002);
    tie(24'h300003, 24'h400004);
    finish_scn("tie_a");

    nack_addr_left = 100;
`ifdef I2C_RANK_SEQ_RETRY_EN
    for (int i = 0; i < 4; i++) exp_addr_nack();
`else
    exp_addr_nack();
`endif
    dexp_q.push_back({1'b0, ERR_ADDR, 32'h0});
    req(0, CMD_R1A, 24'h010203, 1'b0);
    finish_scn("addr_nack");

    nack_data_left = 1;
    exp_op(OP_START, 8'h00, 1'b0);
    exp_op(OP_WRITE, 8'hAA, 1'b0);
    exp_op(OP_WRITE, 8'h31, 1'b0);
    exp_op(OP_STOP, 8'h00, 1'b0);
`ifdef I2C_RANK_SEQ_RETRY_EN
    exp_wframe(8'h31, 24'h445566);
    dexp_q.push_back({1'b0, ERR_OK, 32'h0});
`else
    dexp_q.push_back({1'b0, ERR_DATA, 32'h0});
`endif
    req(0, 8'h31, 24'h445566, 1'b0);
    finish_scn("data_nack");

`ifdef I2C_RANK_SEQ_RETRY_EN
    nack_addr_left = 1;
    exp_addr_nack();
    exp_wframe(CMD_R4B, 24'h0A0B0C);
    dexp_q.push_back({1'b1, ERR_OK, 32'h0});
    req(1, CMD_R4B, 24'h0A0B0C, 1'b0);
    finish_scn("retry_ok");
`endif

    withhold_at = 2;
    exp_op(OP_START, 8'h00, 1'b0);
    exp_op(OP_WRITE, 8'hAA, 1'b0);
    exp_op(OP_WRITE, 8'h21, 1'b0);
    exp_op(OP_STOP, 8'h00, 1'b0);
    dexp_q.push_back({1'b1, ERR_TMO, 32'h0});
    req(1, 8'h21, 24'h010203, 1'b0);
    finish_scn("timeout");

    rd_bytes.push_back(8'hDE); rd_bytes.push_back(8'hAD);
    rd_bytes.push_back(8'hBE); rd_bytes.push_back(8'hEF);
    req(1, CMD_RD2, 24'h0A0B0C, 1'b1);
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      #3;
      found = bc_valid && bc_op == OP_READ && count_reads() == 3;
    end
    chk("rst_mid_reached_rbyte2", 64'(found), 64'd1);
    reset = 1;
    #1;
    chk("rst_mid_bc_valid", 64'(bc_valid), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_done", 64'(done_q.size()), 64'd0);
    got_q.delete(); exp_q.delete(); done_q.delete(); dexp_q.delete();
    gnt_q.delete(); gexp_q.delete(); rd_bytes.delete();
    op_idx = 0;
    last_gnt = 1;

    tie(24'h500005, 24'h600006);
    tie(24'h700007, 24'h800008);
    finish_scn("tie_after_rst");

    chk("ready_single_pulse", 64'(pulse_err), 64'd0);
    chk("bc_hold_stable", 64'(hold_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
